// File: rtl/reservation_station_shell.sv
// Single-entry reservation station: accepts an issue addressed to this station,
// snoops the commit bus for missing operands, runs the attached FU and arbitrates for commit.
module reservation_station_shell #(
  parameter int DATA_W  = 96,
  parameter int ADDR_W  = 16,
  parameter int RS_ID_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [RS_ID_W-1:0] id_i,
  input  logic [RS_ID_W-1:0] issue_rs_id_i,
  input  logic [ADDR_W-1:0]  issue_dst_i,
  input  logic [DATA_W-1:0]  issue_src0_data_i,
  input  logic [DATA_W-1:0]  issue_src1_data_i,
  input  logic [RS_ID_W-1:0] issue_src0_tag_i,
  input  logic [RS_ID_W-1:0] issue_src1_tag_i,
  input  logic [RS_ID_W-1:0] commit_rs_id_i,
  input  logic [DATA_W-1:0]  commit_data_i,
  output logic               busy_o,
  output logic               fu_start_o,
  output logic [DATA_W-1:0]  fu_a_o,
  output logic [DATA_W-1:0]  fu_b_o,
  input  logic               fu_done_i,
  input  logic [DATA_W-1:0]  fu_result_i,
  output logic               commit_request_o,
  input  logic               commit_granted_i,
  output logic [DATA_W-1:0]  commit_data_o,
  output logic [ADDR_W-1:0]  commit_dst_o,
  output logic [RS_ID_W-1:0] commit_rs_id_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]         state_q,  state_d;
  logic [ADDR_W-1:0]  dst_q,    dst_d;
  logic [DATA_W-1:0]  a_q,      a_d;
  logic [DATA_W-1:0]  b_q,      b_d;
  logic [RS_ID_W-1:0] tag0_q,   tag0_d;
  logic [RS_ID_W-1:0] tag1_q,   tag1_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [RS_ID_W-1:0] rs_id_q,  rs_id_d;
  logic               start_q,  start_d;

  logic issue_hit;
  logic fwd0, fwd1;
  logic snoop0, snoop1;

  assign issue_hit = (issue_rs_id_i != '0) && (issue_rs_id_i == id_i);
  // A nonzero tag matching the bus implies the bus is active, so no separate idle test.
  assign fwd0      = (issue_src0_tag_i != '0) && (issue_src0_tag_i == commit_rs_id_i);
  assign fwd1      = (issue_src1_tag_i != '0) && (issue_src1_tag_i == commit_rs_id_i);
  assign snoop0    = (tag0_q != '0) && (tag0_q == commit_rs_id_i);
  assign snoop1    = (tag1_q != '0) && (tag1_q == commit_rs_id_i);

  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    a_d      = a_q;
    b_d      = b_q;
    tag0_d   = tag0_q;
    tag1_d   = tag1_q;
    result_d = result_q;
    rs_id_d  = rs_id_q;
    start_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue_hit) begin
          dst_d  = issue_dst_i;
          a_d    = fwd0 ? commit_data_i : issue_src0_data_i;
          b_d    = fwd1 ? commit_data_i : issue_src1_data_i;
          tag0_d = fwd0 ? '0 : issue_src0_tag_i;
          tag1_d = fwd1 ? '0 : issue_src1_tag_i;
          if ((tag0_d == '0) && (tag1_d == '0)) begin
            state_d = S_EXEC;
            start_d = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (snoop0) begin
          a_d    = commit_data_i;
          tag0_d = '0;
        end
        if (snoop1) begin
          b_d    = commit_data_i;
          tag1_d = '0;
        end
        if ((tag0_d == '0) && (tag1_d == '0)) begin
          state_d = S_EXEC;
          start_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (fu_done_i) begin
          result_d = fu_result_i;
          rs_id_d  = id_i;
          state_d  = S_COMMIT;
        end
      end
      default: begin
        if (commit_granted_i) begin
          rs_id_d = '0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag0_q   <= '0;
      tag1_q   <= '0;
      result_q <= '0;
      rs_id_q  <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag0_q   <= tag0_d;
      tag1_q   <= tag1_d;
      result_q <= result_d;
      rs_id_q  <= rs_id_d;
      start_q  <= start_d;
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign fu_start_o       = start_q;
  assign fu_a_o           = a_q;
  assign fu_b_o           = b_q;
  assign commit_request_o = (state_q == S_COMMIT);
  assign commit_data_o    = result_q;
  assign commit_dst_o     = dst_q;
  assign commit_rs_id_o   = rs_id_q;

endmodule

// File: tb/tb_reservation_station_shell.sv
// Directed bench for reservation_station_shell; expected FU starts and commit
// packets are queued when stimulus is driven and checked when the DUT emits them.
module tb_reservation_station_shell;

  localparam int DATA_W  = 96;
  localparam int ADDR_W  = 16;
  localparam int RS_ID_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [RS_ID_W-1:0] id;
  logic [RS_ID_W-1:0] issue_rs_id;
  logic [ADDR_W-1:0]  issue_dst;
  logic [DATA_W-1:0]  issue_src0_data, issue_src1_data;
  logic [RS_ID_W-1:0] issue_src0_tag, issue_src1_tag;
  logic [RS_ID_W-1:0] commit_rs_id;
  logic [DATA_W-1:0]  commit_data;
  logic               busy, fu_start;
  logic [DATA_W-1:0]  fu_a, fu_b;
  logic               fu_done;
  logic [DATA_W-1:0]  fu_result;
  logic               commit_request, commit_granted;
  logic [DATA_W-1:0]  out_data;
  logic [ADDR_W-1:0]  out_dst;
  logic [RS_ID_W-1:0] out_rs_id;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } start_t;

  typedef struct {
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  dst;
    logic [RS_ID_W-1:0] rs_id;
  } commit_t;

  start_t  start_sb[$];
  commit_t commit_sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reservation_station_shell #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RS_ID_W(RS_ID_W)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .id_i             (id),
    .issue_rs_id_i    (issue_rs_id),
    .issue_dst_i      (issue_dst),
    .issue_src0_data_i(issue_src0_data),
    .issue_src1_data_i(issue_src1_data),
    .issue_src0_tag_i (issue_src0_tag),
    .issue_src1_tag_i (issue_src1_tag),
    .commit_rs_id_i   (commit_rs_id),
    .commit_data_i    (commit_data),
    .busy_o           (busy),
    .fu_start_o       (fu_start),
    .fu_a_o           (fu_a),
    .fu_b_o           (fu_b),
    .fu_done_i        (fu_done),
    .fu_result_i      (fu_result),
    .commit_request_o (commit_request),
    .commit_granted_i (commit_granted),
    .commit_data_o    (out_data),
    .commit_dst_o     (out_dst),
    .commit_rs_id_o   (out_rs_id)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_rs_id     = '0;
    issue_dst       = '0;
    issue_src0_data = '0;
    issue_src1_data = '0;
    issue_src0_tag  = '0;
    issue_src1_tag  = '0;
    commit_rs_id    = '0;
    commit_data     = '0;
    fu_done         = 1'b0;
    fu_result       = '0;
    commit_granted  = 1'b0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] dst, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [RS_ID_W-1:0] t0, input logic [RS_ID_W-1:0] t1);
    issue_rs_id     = 4'd3;
    issue_dst       = dst;
    issue_src0_data = a;
    issue_src1_data = b;
    issue_src0_tag  = t0;
    issue_src1_tag  = t1;
  endtask

  task automatic end_issue();
    issue_rs_id = '0;
    issue_src0_tag = '0;
    issue_src1_tag = '0;
  endtask

  task automatic expect_start(input string tag);
    start_t e;
    chk({tag, ".start"}, fu_start, 1);
    if (start_sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb: observed empty start queue expected an entry", tag);
    end else begin
      e = start_sb.pop_front();
      chk({tag, ".a"}, fu_a, e.a);
      chk({tag, ".b"}, fu_b, e.b);
    end
  endtask

  task automatic expect_commit(input string tag);
    commit_t e;
    chk({tag, ".req"}, commit_request, 1);
    if (commit_sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb: observed empty commit queue expected an entry", tag);
    end else begin
      e = commit_sb.pop_front();
      chk({tag, ".data"}, out_data, e.data);
      chk({tag, ".dst"}, out_dst, {{(DATA_W-ADDR_W){1'b0}}, e.dst});
      chk({tag, ".rsid"}, out_rs_id, {{(DATA_W-RS_ID_W){1'b0}}, e.rs_id});
    end
  endtask

  // FU completes now, the packet is checked next cycle, then granted at once.
  task automatic finish_op(input string tag, input logic [DATA_W-1:0] res, input logic [ADDR_W-1:0] dst);
    fu_done   = 1'b1;
    fu_result = res;
    commit_sb.push_back('{data: res, dst: dst, rs_id: 4'd3});
    step();
    fu_done = 1'b0;
    expect_commit(tag);
    commit_granted = 1'b1;
    step();
    commit_granted = 1'b0;
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".idle_req"}, commit_request, 0);
    chk({tag, ".idle_rsid"}, out_rs_id, 0);
  endtask

  initial begin
    id    = 4'd3;
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    chk("reset.busy", busy, 0);
    chk("reset.start", fu_start, 0);
    chk("reset.req", commit_request, 0);
    chk("reset.rsid", out_rs_id, 0);
    chk("reset.data", out_data, 0);
    chk("reset.a", fu_a, 0);
    rst_n = 1'b1;
    step();

    // Stray done and grant in IDLE are ignored.
    fu_done = 1'b1; fu_result = 96'h99; commit_granted = 1'b1;
    step();
    clear_inputs();
    chk("idle_ignore.busy", busy, 0);
    chk("idle_ignore.req", commit_request, 0);
    chk("idle_ignore.data", out_data, 0);

    // Ready issue: start at N+1, done at N+3, request at N+4, grant at N+6.
    issue(16'h0010, 96'd1, 96'd2, 4'd0, 4'd0);
    start_sb.push_back('{a: 96'd1, b: 96'd2});
    step();
    end_issue();
    chk("ready.busy", busy, 1);
    expect_start("ready");
    step();
    chk("ready.pulse_end", fu_start, 0);
    step();
    fu_done = 1'b1; fu_result = 96'd3;
    commit_sb.push_back('{data: 96'd3, dst: 16'h0010, rs_id: 4'd3});
    step();
    fu_done = 1'b0;
    expect_commit("ready");
    step();
    commit_granted = 1'b1;
    step();
    commit_granted = 1'b0;
    chk("ready.busy_after_grant", busy, 0);
    chk("ready.req_after_grant", commit_request, 0);

    // Dependent operand resolved five cycles after issue; commits from RsId 4 ignored.
    issue(16'h0020, 96'hDEAD, 96'd9, 4'd2, 4'd0);
    step();
    end_issue();
    chk("dep.busy", busy, 1);
    chk("dep.no_start", fu_start, 0);
    step();
    commit_rs_id = 4'd4; commit_data = 96'h99;
    step();
    commit_rs_id = '0;
    chk("dep.other_commit_a", fu_a, 96'hDEAD);
    step();
    chk("dep.still_waiting", fu_start, 0);
    step();
    commit_rs_id = 4'd2; commit_data = 96'h55;
    start_sb.push_back('{a: 96'h55, b: 96'd9});
    step();
    commit_rs_id = '0;
    expect_start("dep");
    step();
    chk("dep.pulse_end", fu_start, 0);
    fu_done = 1'b1; fu_result = 96'h1234;
    commit_sb.push_back('{data: 96'h1234, dst: 16'h0020, rs_id: 4'd3});
    step();
    fu_done = 1'b0;
    expect_commit("dep");

    // Grant withheld for 10 cycles; an issue during the window is ignored.
    for (int i = 0; i < 10; i++) begin
      if (i == 3) issue(16'h0077, 96'hBAD, 96'hBAD, 4'd0, 4'd0);
      step();
      end_issue();
      chk($sformatf("hold%0d.req", i), commit_request, 1);
      chk($sformatf("hold%0d.data", i), out_data, 96'h1234);
      chk($sformatf("hold%0d.dst", i), out_dst, 96'h0020);
      chk($sformatf("hold%0d.busy", i), busy, 1);
    end
    chk("hold.a_kept", fu_a, 96'h55);
    chk("hold.no_start", fu_start, 0);
    commit_granted = 1'b1;
    step();
    commit_granted = 1'b0;
    chk("hold.busy_after_grant", busy, 0);

    // Same-cycle forwarding at issue goes straight to EXEC.
    issue(16'h0030, 96'h44, 96'h11, 4'd0, 4'd5);
    commit_rs_id = 4'd5; commit_data = 96'hAA;
    start_sb.push_back('{a: 96'h44, b: 96'hAA});
    step();
    end_issue();
    commit_rs_id = '0;
    expect_start("fwd");
    finish_op("fwd", 96'h5A5A, 16'h0030);

    // Both tags resolved by one commit, single start pulse.
    issue(16'h0040, 96'h0, 96'h0, 4'd1, 4'd1);
    step();
    end_issue();
    step();
    commit_rs_id = 4'd1; commit_data = 96'd7;
    start_sb.push_back('{a: 96'd7, b: 96'd7});
    step();
    commit_rs_id = '0;
    expect_start("both");
    step();
    chk("both.single_pulse", fu_start, 0);
    finish_op("both", 96'd14, 16'h0040);

    // Asynchronous reset mid-EXEC, then a late done must not raise a request.
    issue(16'h0050, 96'h21, 96'h22, 4'd0, 4'd0);
    start_sb.push_back('{a: 96'h21, b: 96'h22});
    step();
    end_issue();
    expect_start("rst_exec");
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst.busy", busy, 0);
    chk("async_rst.a", fu_a, 0);
    chk("async_rst.b", fu_b, 0);
    chk("async_rst.dst", out_dst, 0);
    step();
    rst_n = 1'b1;
    step();
    fu_done = 1'b1; fu_result = 96'h77;
    step();
    fu_done = 1'b0;
    chk("late_done.req", commit_request, 0);
    chk("late_done.busy", busy, 0);
    step();
    chk("late_done.req2", commit_request, 0);
    chk("late_done.data", out_data, 0);

    chk("sb.start_empty", start_sb.size(), 0);
    chk("sb.commit_empty", commit_sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
